// File: rtl/window_stream_buffer_pkg.sv
// Shared defaults, cycle classification and tap indexing for the
// sliding-window line buffer.
package window_stream_buffer_pkg;

    localparam int unsigned WORD_SIZE        = 8;
    localparam int unsigned DEF_FRAME_WIDTH  = 640;
    localparam int unsigned DEF_FRAME_HEIGHT = 480;

    typedef enum logic [1:0] {
        CYC_PIXEL,
        CYC_ROW,
        CYC_FRAME
    } cycle_e;

    function automatic int unsigned tap_idx(input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned ksize);
        return r * ksize + c;
    endfunction

endpackage

// File: rtl/line_ram.sv
// One row of pixel storage: synchronous write, asynchronous read.
module line_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 640
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/window_stream_buffer.sv
// Raster line buffer producing a KSIZE x KSIZE neighbourhood per accepted
// pixel, with centre coordinates, frame counting and overflow detection.
module window_stream_buffer
    import window_stream_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = WORD_SIZE,
    parameter int unsigned KSIZE        = 3,
    parameter int unsigned FRAME_WIDTH  = DEF_FRAME_WIDTH,
    parameter int unsigned FRAME_HEIGHT = DEF_FRAME_HEIGHT,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned COORD_WIDTH  = 16
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                en,
    input  logic                                hsync,
    input  logic                                vsync,
    input  logic [DATA_WIDTH-1:0]               data_in,
    output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   window_out,
    output logic                                valid_out,
    output logic [COORD_WIDTH-1:0]              xc_out,
    output logic [COORD_WIDTH-1:0]              yc_out,
    output logic [31:0]                         frame_cnt,
    output logic                                overflow_err
);

    localparam int unsigned XW = ADDR_WIDTH + 1;
    localparam int unsigned WW = KSIZE * KSIZE * DATA_WIDTH;
    localparam logic [XW-1:0] X_LIMIT = XW'(FRAME_WIDTH);
    localparam logic [XW-1:0] Y_LIMIT = XW'(FRAME_HEIGHT);
    localparam logic [XW-1:0] EDGE    = XW'(KSIZE - 1);
    localparam logic [XW-1:0] HALF    = XW'((KSIZE - 1) / 2);

    cycle_e                           cyc;
    logic [XW-1:0]                    x_q;
    logic [XW-1:0]                    y_q;
    logic                             in_range;
    logic                             accept;
    logic                             win_full;
    logic [ADDR_WIDTH-1:0]            addr;
    logic [KSIZE-2:0][DATA_WIDTH-1:0] ram_rd;
    logic [KSIZE-1:0][DATA_WIDTH-1:0] col;
    logic [WW-1:0]                    window_d;

    always_comb begin
        cyc = CYC_PIXEL;
        if (vsync) begin
            cyc = CYC_FRAME;
        end else if (hsync) begin
            cyc = CYC_ROW;
        end
    end

    assign in_range = (x_q < X_LIMIT) && (y_q < Y_LIMIT);
    assign accept   = en && (cyc == CYC_PIXEL) && in_range;
    assign win_full = (x_q >= EDGE) && (y_q >= EDGE);
    assign addr     = x_q[ADDR_WIDTH-1:0];

    // RAM j holds the row j+1 above the current one; each write pushes the
    // column down the chain so reads see the pre-write (older) values.
    for (genvar j = 0; j < KSIZE - 1; j++) begin : g_line
        logic [DATA_WIDTH-1:0] wdata;
        if (j == 0) begin : g_first
            assign wdata = data_in;
        end else begin : g_next
            assign wdata = ram_rd[j-1];
        end
        line_ram #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .DEPTH     (FRAME_WIDTH)
        ) u_ram (
            .clk  (clk),
            .we   (accept),
            .waddr(addr),
            .wdata(wdata),
            .raddr(addr),
            .rdata(ram_rd[j])
        );
        assign col[KSIZE-2-j] = ram_rd[j];
    end

    assign col[KSIZE-1] = data_in;

    for (genvar r = 0; r < KSIZE; r++) begin : g_row
        for (genvar c = 0; c < KSIZE; c++) begin : g_col
            localparam int unsigned DST = tap_idx(r, c, KSIZE) * DATA_WIDTH;
            if (c == KSIZE - 1) begin : g_load
                assign window_d[DST +: DATA_WIDTH] = col[r];
            end else begin : g_shift
                assign window_d[DST +: DATA_WIDTH] = window_out[DST + DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_q          <= '0;
            y_q          <= '0;
            frame_cnt    <= '0;
            valid_out    <= 1'b0;
            overflow_err <= 1'b0;
            window_out   <= '0;
            xc_out       <= '0;
            yc_out       <= '0;
        end else begin
            valid_out <= 1'b0;
            if (en) begin
                unique case (cyc)
                    CYC_FRAME: begin
                        x_q       <= '0;
                        y_q       <= '0;
                        frame_cnt <= frame_cnt + 32'd1;
                    end
                    CYC_ROW: begin
                        x_q <= '0;
                        if (y_q < Y_LIMIT) begin
                            y_q <= y_q + 1'b1;
                        end
                    end
                    CYC_PIXEL: begin
                        if (in_range) begin
                            x_q        <= x_q + 1'b1;
                            window_out <= window_d;
                            if (win_full) begin
                                valid_out <= 1'b1;
                                xc_out    <= COORD_WIDTH'(x_q - HALF);
                                yc_out    <= COORD_WIDTH'(y_q - HALF);
                            end
                        end else begin
                            overflow_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
